// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester ports and controller command bus around the SDRAM arbiter.
// The slave modport is the arbiter side; master is the requesters plus controller side.
interface sdram_arbiter_if #(
   parameter int AW = 24,
   parameter int DW = 16
);
   logic          p0Req, p0We, p0Ack;
   logic          p1Req, p1We, p1Ack;
   logic [AW-1:0] p0A, p1A, ctlA;
   logic [DW-1:0] p0D, p0Q, p1D, p1Q, ctlD, ctlQ;
   logic          ctlRf, ctlRd, ctlWr;

   modport slave (
      input  p0Req, p0We, p0A, p0D, p1Req, p1We, p1A, p1D, ctlQ,
      output p0Q, p0Ack, p1Q, p1Ack, ctlRf, ctlRd, ctlWr, ctlA, ctlD
   );

   modport master (
      output p0Req, p0We, p0A, p0D, p1Req, p1We, p1A, p1D, ctlQ,
      input  p0Q, p0Ack, p1Q, p1Ack, ctlRf, ctlRd, ctlWr, ctlA, ctlD
   );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller between the CPU port, the bulk port and auto-refresh,
// issuing one-cycle commands and holding the controller for a fixed slot per operation.
module sdram_arbiter #(
   parameter int AW       = 24,
   parameter int DW       = 16,
   parameter int TOP      = 8,
   parameter int QLAT     = 6,
   parameter int RFPERIOD = 420,
   parameter int RFURGENT = 64
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           ready,
   sdram_arbiter_if.slave bus,
   output logic           busy,
   output logic           rfOver
);
   localparam int CW = $clog2(TOP + 1);
   localparam int RW = $clog2(RFPERIOD);
   localparam int GW = $clog2(RFURGENT + 1);

   typedef enum logic {IDLE, SLOT} state_t;
   typedef enum logic [1:0] {OWN_RF, OWN_P0, OWN_P1} owner_t;

   state_t        state, state_nx;
   owner_t        owner, owner_nx;
   logic [CW-1:0] cnt;
   logic [RW-1:0] rf_cnt;
   logic [GW-1:0] rf_age;
   logic          rf_pend, rf_urgent, rf_wrap, rf_grant;
   logic          el0, el1, grant, port_grant, last, cap, op_rd, we_sel;
   logic [AW-1:0] a_sel;
   logic [DW-1:0] d_sel;

   // a port in its ack cycle is not eligible, so a held request is not granted twice
   assign el0       = bus.p0Req && !bus.p0Ack;
   assign el1       = bus.p1Req && !bus.p1Ack;
   assign rf_urgent = rf_pend && rf_age >= GW'(RFURGENT);
   assign rf_wrap   = ready && rf_cnt == RW'(RFPERIOD - 1);
   assign busy      = state == SLOT;

   always_comb begin
      grant      = state == IDLE && ready && (rf_pend || el0 || el1);
      owner_nx   = rf_urgent ? OWN_RF : el0 ? OWN_P0 : el1 ? OWN_P1 : OWN_RF;
      port_grant = grant && owner_nx != OWN_RF;
      rf_grant   = grant && owner_nx == OWN_RF;
      we_sel     = owner_nx == OWN_P1 ? bus.p1We : bus.p0We;
      a_sel      = owner_nx == OWN_P1 ? bus.p1A : bus.p0A;
      d_sel      = owner_nx == OWN_P1 ? bus.p1D : bus.p0D;
      last       = state == SLOT && cnt == CW'(TOP - 1);
      cap        = state == SLOT && op_rd && cnt == CW'(QLAT);
      state_nx   = grant ? SLOT : last ? IDLE : state;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= OWN_RF;
         cnt       <= '0;
         op_rd     <= 1'b0;
         rf_cnt    <= '0;
         rf_age    <= '0;
         rf_pend   <= 1'b0;
         rfOver    <= 1'b0;
         bus.ctlRf <= 1'b0;
         bus.ctlRd <= 1'b0;
         bus.ctlWr <= 1'b0;
         bus.ctlA  <= '0;
         bus.ctlD  <= '0;
         bus.p0Q   <= '0;
         bus.p1Q   <= '0;
         bus.p0Ack <= 1'b0;
         bus.p1Ack <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= grant ? '0 : state == SLOT ? cnt + 1'b1 : cnt;
         owner     <= grant ? owner_nx : owner;
         op_rd     <= grant ? port_grant && !we_sel : op_rd;
         bus.ctlRf <= rf_grant;
         bus.ctlRd <= port_grant && !we_sel;
         bus.ctlWr <= port_grant && we_sel;
         bus.ctlA  <= port_grant ? a_sel : bus.ctlA;
         bus.ctlD  <= port_grant ? d_sel : bus.ctlD;
         bus.p0Q   <= cap && owner == OWN_P0 ? bus.ctlQ : bus.p0Q;
         bus.p1Q   <= cap && owner == OWN_P1 ? bus.ctlQ : bus.p1Q;
         bus.p0Ack <= last && owner == OWN_P0;
         bus.p1Ack <= last && owner == OWN_P1;
         rf_cnt    <= !ready ? rf_cnt : rf_wrap ? '0 : rf_cnt + 1'b1;
         rf_pend   <= rf_wrap || (rf_pend && !rf_grant);
         rf_age    <= rf_grant ? '0 : rf_pend && !rf_urgent ? rf_age + 1'b1 : rf_age;
         rfOver    <= rfOver || (rf_wrap && rf_pend);
      end
   end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port between the CPU memory port, a secondary bulk-transfer port (SD-card loader / DMA), and periodic auto-refresh. It sits between the core and the `sdram` controller. It issues one-cycle command pulses with address and data to the controller, then holds the controller for a fixed slot length. During the slot it captures read data at a fixed offset and acknowledges the owning requester. Fixed priority applies, with an aging override so refresh can never be starved by CPU traffic.

## Interface
Parameters:
- AW, 24, address width of both ports and the controller
- DW, 16, data width of both ports and the controller
- TOP, 8, cycles per controller operation (slot length), ≥ QLAT+2
- QLAT, 6, slot cycle at which controller read data `ctlQ` is valid
- RFPERIOD, 420, cycles between refresh requests (7.5 µs at 56 MHz)
- RFURGENT, 64, cycles a pending refresh waits before it pre-empts all ports

Ports (clock and reset first):
- clock  in  1  system clock (56 MHz); all logic on rising edge
- reset  in  1  asynchronous, active-low; low clears all state
- ready  in  1  controller initialisation done; no grants or refresh timing while low
- p0Req  in  1  CPU request, level, held until p0Ack
- p0We  in  1  CPU write (1) / read (0), stable while p0Req
- p0A  in  AW  CPU address
- p0D  in  DW  CPU write data
- p0Q  out  DW  CPU read data, registered
- p0Ack  out  1  one-cycle completion strobe
- p1Req, p1We, p1A, p1D, p1Q, p1Ack: same as p0, secondary port
- ctlRf  out  1  refresh command pulse
- ctlRd  out  1  read command pulse
- ctlWr  out  1  write command pulse
- ctlA  out  AW  controller address, registered at grant
- ctlD  out  DW  controller write data, registered at grant
- ctlQ  in  DW  controller read data
- busy  out  1  slot in progress
- rfOver  out  1  sticky: a refresh period expired while the previous refresh was still pending

## Operation
- States: IDLE, SLOT. Reset puts the block in IDLE with every output 0 and all counters 0. p0Q and p1Q also reset to 0.
- Eligibility in IDLE (evaluated each cycle with ready=1). A port is eligible when its Req=1 and its Ack is not high that cycle. This prevents a re-grant on the ack cycle.
- Priority: urgent refresh > p0 > p1 > pending (non-urgent) refresh.
- Grant edge:
  - state→SLOT, slot counter cnt←0, owner register set, busy←1.
  - Exactly one of ctlRf/ctlRd/ctlWr←1. ctlRd or ctlWr is selected by the owner's We.
  - ctlA←owner A and ctlD←owner D for port grants. For refresh, ctlA and ctlD keep their previous values.
- All command pulses are high for exactly one cycle.
- SLOT:
  - cnt increments each edge.
  - At the edge where cnt==QLAT on a port read, the owner's Q←ctlQ.
  - At the edge where cnt==TOP-1: state→IDLE, busy←0, and the owner's Ack←1 for one cycle. Refresh produces no ack.
- Refresh timer:
  - Counts only while ready=1. At RFPERIOD-1 it wraps to 0 and sets rfPend.
  - If rfPend is already set at the wrap, rfOver←1. It stays set until reset.
  - rfAge counts while rfPend=1 and clears when the refresh is granted. Urgent means rfAge ≥ RFURGENT.
  - Granting a refresh clears rfPend.
- ready low: IDLE makes no grants and the refresh timer holds. A slot already in progress completes normally.
- Reset mid-slot: the operation is abandoned with no ack, and all outputs go to 0 immediately. Requesters must re-request.
- Port Q holds its last captured value until that port's next read capture. Writes never change Q.

## Timing
- Request visible at edge n with the block in IDLE and the port winning → command pulse high during cycle n..n+1.
- Read data is captured into Q at edge n+QLAT+1.
- Ack is high during the cycle after edge n+TOP, together with valid Q.
- Port-to-port back-to-back service: the next grant comes at the edge after the ack cycle begins. Minimum spacing between command pulses is TOP+1 cycles.
- Worst-case refresh delay after rfPend is RFURGENT + TOP + 1 cycles.
- p0 worst-case wait is one slot plus one refresh slot. p1 can wait indefinitely under continuous p0 load; this is by design.

## Test plan
- **p0 read:** controller model drives ctlQ=16'hA55A only at slot cycle QLAT. Assert p0Req=1, p0We=0, p0A=24'h001234.
  - Expect ctlRd pulse with ctlA=24'h001234.
  - Expect p0Ack 8 cycles after the pulse with p0Q=16'hA55A.
  - Expect no second ctlRd while p0Req drops during the ack cycle.
- **Simultaneous requests:** p0 write 16'h00FF to 24'h000010 and p1 read of 24'h020000 raised on the same edge.
  - Expect ctlWr first, then ctlRd with ctlA=24'h020000 exactly 9 cycles later.
  - Expect p1Ack after p0Ack.
- **Idle refresh:** ready=1, no requests. Expect ctlRf pulses exactly 420 cycles apart, busy high 8 cycles each, rfOver=0.
- **Starvation guard:** p0Req held high continuously.
  - Expect ctlRf to occur within 64+9 cycles of rfPend.
  - Expect p0 service to resume in the following slot and rfOver to stay 0.
- **Reset mid-slot:** drop reset low at slot cycle 3 of a p1 read.
  - Expect all outputs 0 immediately and no p1Ack.
  - After release with p1Req still high, expect a fresh ctlRd.
- **ready low:** with p0Req=1, expect no ctl pulses and a frozen refresh timer. The first ctlRd occurs 1 cycle after ready rises.
